fade_sequencer: RTL

//  Upstream stage for the PWM generator: produces duty_cycle/period words that drive a breathing/fade effect.

---
 rtl/fade_sequencer_if.sv | 22 ++
 rtl/fade_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fade_sequencer_if.sv
// Handshake bundle between the fade sequencer and its controller / PWM generator.
// The master side drives the fade controls; the slave side (the sequencer) drives the PWM words.
interface fade_sequencer_if;
    logic        enable;
    logic [15:0] min_duty;
    logic [15:0] max_duty;
    logic [7:0]  step;
    logic [15:0] duty_cycle;
    logic [15:0] period;
    logic [2:0]  phase;
    logic        cycle_done;

    modport master (
        output enable, min_duty, max_duty, step,
        input  duty_cycle, period, phase, cycle_done
    );

    modport slave (
        input  enable, min_duty, max_duty, step,
        output duty_cycle, period, phase, cycle_done
    );
endinterface

// File: rtl/fade_sequencer.sv
// Breathing/fade duty generator feeding a PWM generator: linear ramp between latched limits with end holds.
// Optional build macro FADE_GAMMA_EN squares the duty curve (lin*lin/PERIOD) with one extra clock of latency.
module fade_sequencer #(
    parameter int CLK_FREQ   = 25_000_000,
    parameter int PWM_FREQ   = 1250,
    parameter int STEP_DIV   = 1000,
    parameter int HOLD_TICKS = 2500
) (
    input  logic            clk,
    input  logic            rst_n,
    fade_sequencer_if.slave bus
);
    localparam int          PERIOD     = CLK_FREQ / PWM_FREQ;
    localparam logic [15:0] PERIOD_W   = 16'(PERIOD);
    localparam int          PRE_W      = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int          HOLD_W     = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(STEP_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RAMP_UP   = 3'd1,
        HOLD_HIGH = 3'd2,
        RAMP_DOWN = 3'd3,
        HOLD_LOW  = 3'd4
    } phase_t;

    phase_t            state_r;
    logic [PRE_W-1:0]  pre_r;
    logic [HOLD_W-1:0] hold_r;
    logic [15:0]       lin_r;
    logic [15:0]       hi_r;
    logic [15:0]       lo_r;
    logic              done_r;
    logic [15:0]       period_r;

    logic              tick_s;
    logic [16:0]       step_s;
    logic [16:0]       up_sum_s;
    logic [16:0]       lo_plus_s;
    logic [15:0]       hi_new_s;
    logic [15:0]       lo_new_s;

    // Step tick, effective step and clamped limits for the next latch point.
    always_comb begin
        tick_s    = 1'b0;
        step_s    = 17'd1;
        hi_new_s  = bus.max_duty;
        lo_new_s  = bus.min_duty;
        if (bus.enable && (state_r != IDLE) && (pre_r == PRE_LAST)) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
        if (bus.step == 8'd0) begin
            step_s = 17'd1;
        end else begin
            step_s = {9'd0, bus.step};
        end
        if (bus.max_duty > PERIOD_W) begin
            hi_new_s = PERIOD_W;
        end else begin
            hi_new_s = bus.max_duty;
        end
        if (bus.min_duty > hi_new_s) begin
            lo_new_s = hi_new_s;
        end else begin
            lo_new_s = bus.min_duty;
        end
        up_sum_s  = {1'b0, lin_r} + step_s;
        lo_plus_s = {1'b0, lo_r} + step_s;
    end

    // Step-rate prescaler; held at zero while idle or disabled so each run starts aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_r <= '0;
        end else if (!bus.enable || (state_r == IDLE) || tick_s) begin
            pre_r <= '0;
        end else begin
            pre_r <= pre_r + PRE_W'(1);
        end
    end

    // Fade state machine with the linear duty and cycle_done registered alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            hold_r  <= '0;
            lin_r   <= 16'd0;
            hi_r    <= 16'd0;
            lo_r    <= 16'd0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (!bus.enable) begin
                state_r <= IDLE;
                hold_r  <= '0;
                lin_r   <= 16'd0;
            end else begin
                case (state_r)
                    IDLE: begin
                        hi_r    <= hi_new_s;
                        lo_r    <= lo_new_s;
                        lin_r   <= lo_new_s;
                        state_r <= RAMP_UP;
                    end
                    RAMP_UP: begin
                        if (tick_s) begin
                            if (up_sum_s >= {1'b0, hi_r}) begin
                                lin_r   <= hi_r;
                                hold_r  <= '0;
                                state_r <= HOLD_HIGH;
                            end else begin
                                lin_r <= up_sum_s[15:0];
                            end
                        end
                    end
                    HOLD_HIGH: begin
                        if (tick_s) begin
                            if (hold_r == HOLD_LAST) begin
                                state_r <= RAMP_DOWN;
                            end else begin
                                hold_r <= hold_r + HOLD_W'(1);
                            end
                        end
                    end
                    RAMP_DOWN: begin
                        if (tick_s) begin
                            if ({1'b0, lin_r} <= lo_plus_s) begin
                                lin_r   <= lo_r;
                                hold_r  <= '0;
                                state_r <= HOLD_LOW;
                            end else begin
                                lin_r <= lin_r - step_s[15:0];
                            end
                        end
                    end
                    HOLD_LOW: begin
                        if (tick_s) begin
                            if (hold_r == HOLD_LAST) begin
                                hi_r    <= hi_new_s;
                                lo_r    <= lo_new_s;
                                lin_r   <= lo_new_s;
                                done_r  <= 1'b1;
                                state_r <= RAMP_UP;
                            end else begin
                                hold_r <= hold_r + HOLD_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        hold_r  <= '0;
                        lin_r   <= 16'd0;
                    end
                endcase
            end
        end
    end

    // Period word is a reset-loaded constant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_r <= PERIOD_W;
        end else begin
            period_r <= period_r;
        end
    end

    assign bus.period = period_r;

`ifdef FADE_GAMMA_EN
    logic [15:0] gamma_r;
    logic [2:0]  phase_d_r;
    logic        done_d_r;

    // Squared duty curve; lin <= PERIOD so the quotient always fits 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gamma_r   <= 16'd0;
            phase_d_r <= 3'd0;
            done_d_r  <= 1'b0;
        end else begin
            gamma_r   <= 16'((32'(lin_r) * 32'(lin_r)) / 32'(PERIOD));
            phase_d_r <= state_r;
            done_d_r  <= done_r;
        end
    end

    assign bus.duty_cycle = gamma_r;
    assign bus.phase      = phase_d_r;
    assign bus.cycle_done = done_d_r;
`else
    assign bus.duty_cycle = lin_r;
    assign bus.phase      = state_r;
    assign bus.cycle_done = done_r;
`endif

endmodule
